// File: rtl/cathode_scan_decoder.sv
// Recovers the BCD frame shown on a multiplexed active-low 7-segment display
// from its anode strobes and cathode bus, publishing one frame per full scan.
module cathode_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   anode,
   input  logic [7:0]              cathode,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   dp,
   output logic                    valid,
   output logic                    frame_err
);

   localparam int SW = NUM_DIGITS + 8;
   // The incoming sample is compared with the held one, so the first match
   // already covers two samples; capture fires when STABLE_CYCLES have matched.
   localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 2);

   typedef enum logic {ST_COUNT = 1'b0, ST_HOLD = 1'b1} state_t;

   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'h40:   seg_decode = {1'b0, 4'd0};
         7'h79:   seg_decode = {1'b0, 4'd1};
         7'h24:   seg_decode = {1'b0, 4'd2};
         7'h30:   seg_decode = {1'b0, 4'd3};
         7'h19:   seg_decode = {1'b0, 4'd4};
         7'h12:   seg_decode = {1'b0, 4'd5};
         7'h02:   seg_decode = {1'b0, 4'd6};
         7'h78:   seg_decode = {1'b0, 4'd7};
         7'h00:   seg_decode = {1'b0, 4'd8};
         7'h10:   seg_decode = {1'b0, 4'd9};
         default: seg_decode = {1'b1, 4'hF};
      endcase
   endfunction

   function automatic logic one_low(input logic [NUM_DIGITS-1:0] a);
      logic [7:0] n;
      n = 8'd0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         n = n + {7'd0, ~a[k]};
      end
      return (n == 8'd1);
   endfunction

   logic [SW-1:0]           r_cur;
   state_t                  r_state;
   logic [7:0]              r_cnt;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [NUM_DIGITS-1:0]   r_shadow_dp;
   logic [NUM_DIGITS-1:0]   r_shadow_err;
   logic [NUM_DIGITS-1:0]   r_seen;
   logic                    r_pub_pending;

   logic [SW-1:0]           w_sample;
   logic                    w_match;
   logic                    w_legal;
   logic [4:0]              w_dec;
   logic                    w_capture;
   logic [NUM_DIGITS-1:0]   w_cap_mask;
   logic [NUM_DIGITS-1:0]   w_seen_next;

   assign w_sample = {anode, cathode};
   assign w_match  = (w_sample == r_cur);
   assign w_legal  = one_low(r_cur[SW-1:8]);
   assign w_dec    = seg_decode(r_cur[6:0]);

   // Capture decision and the seen set after this edge (a publish clears it first).
   always_comb begin
      w_capture   = 1'b0;
      w_cap_mask  = {NUM_DIGITS{1'b0}};
      w_seen_next = {NUM_DIGITS{1'b0}};
      if ((r_state == ST_COUNT) && w_match && w_legal && (r_cnt == CAP_CNT)) begin
         w_capture  = 1'b1;
         w_cap_mask = ~r_cur[SW-1:8];
      end else begin
         w_capture  = 1'b0;
         w_cap_mask = {NUM_DIGITS{1'b0}};
      end
      if (r_pub_pending) begin
         w_seen_next = w_cap_mask;
      end else begin
         w_seen_next = r_seen | w_cap_mask;
      end
   end

   // Sampling, dwell FSM, shadow capture and frame publish.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cur         <= {{NUM_DIGITS{1'b1}}, 8'hFF};
         r_state       <= ST_COUNT;
         r_cnt         <= 8'd0;
         r_shadow      <= {(4*NUM_DIGITS){1'b0}};
         r_shadow_dp   <= {NUM_DIGITS{1'b0}};
         r_shadow_err  <= {NUM_DIGITS{1'b0}};
         r_seen        <= {NUM_DIGITS{1'b0}};
         r_pub_pending <= 1'b0;
         digits        <= {(4*NUM_DIGITS){1'b0}};
         dp            <= {NUM_DIGITS{1'b0}};
         valid         <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         r_cur <= w_sample;
         case (r_state)
            ST_COUNT: begin
               if (w_match && w_legal) begin
                  if (r_cnt == CAP_CNT) begin
                     r_cnt   <= 8'd0;
                     r_state <= ST_HOLD;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end else begin
                  r_cnt <= 8'd0;
               end
            end
            ST_HOLD: begin
               if (!w_match) begin
                  r_cnt   <= 8'd0;
                  r_state <= ST_COUNT;
               end else begin
                  r_cnt <= 8'd0;
               end
            end
            default: begin
               r_cnt   <= 8'd0;
               r_state <= ST_COUNT;
            end
         endcase
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_cap_mask[k]) begin
               r_shadow[4*k +: 4] <= w_dec[3:0];
               r_shadow_dp[k]     <= ~r_cur[7];
               r_shadow_err[k]    <= w_dec[4];
            end
         end
         r_seen        <= w_seen_next;
         r_pub_pending <= w_capture && (&w_seen_next);
         valid         <= r_pub_pending;
         if (r_pub_pending) begin
            digits    <= r_shadow;
            dp        <= r_shadow_dp;
            frame_err <= |r_shadow_err;
         end
      end
   end

endmodule

// File: tb/tb_cathode_scan_decoder.sv
// Randomised and directed bench for cathode_scan_decoder against a dwell/frame
// reference model built from input run lengths and a segment lookup table.
module tb_cathode_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [ND-1:0] anode;
   logic [7:0]    cathode;
   logic [4*ND-1:0] digits;
   logic [ND-1:0] dp;
   logic          valid;
   logic          frame_err;

   cathode_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .anode(anode), .cathode(cathode),
      .digits(digits), .dp(dp), .valid(valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int edge_no = 0;
   int valid_seen = 0;
   int last_valid_edge = 0;

   logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // reference model state
   logic [ND+7:0] m_last;
   int            m_run;
   logic [3:0]    m_dig [ND];
   logic          m_dp  [ND];
   logic          m_err [ND];
   logic          m_seen [ND];
   logic          m_pending;
   logic [4*ND-1:0] m_out_digits;
   logic [ND-1:0] m_out_dp;
   logic          m_out_err;
   logic          m_valid;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_no, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst, input logic [ND-1:0] a, input logic [7:0] c);
      int zeros, pos, val, all_seen;
      if (rst) begin
         m_last = {{ND{1'b1}}, 8'hFF};
         m_run = 0;
         for (int k = 0; k < ND; k++) begin
            m_dig[k] = 4'd0; m_dp[k] = 1'b0; m_err[k] = 1'b0; m_seen[k] = 1'b0;
         end
         m_pending = 1'b0; m_out_digits = '0; m_out_dp = '0; m_out_err = 1'b0; m_valid = 1'b0;
         return;
      end
      m_valid = m_pending;
      if (m_pending) begin
         m_out_err = 1'b0;
         for (int k = 0; k < ND; k++) begin
            m_out_digits[4*k +: 4] = m_dig[k];
            m_out_dp[k] = m_dp[k];
            m_out_err = m_out_err | m_err[k];
            m_seen[k] = 1'b0;
         end
      end
      m_pending = 1'b0;
      if ({a, c} == m_last) m_run++;
      else m_run = 1;
      m_last = {a, c};
      zeros = 0; pos = 0;
      for (int k = 0; k < ND; k++) begin
         if (!a[k]) begin zeros++; pos = k; end
      end
      if (m_run == SC && zeros == 1) begin
         val = 15;
         for (int i = 0; i < 10; i++) if (seg_tbl[i] == c[6:0]) val = i;
         m_dig[pos] = 4'(val);
         m_err[pos] = (val == 15);
         m_dp[pos] = ~c[7];
         m_seen[pos] = 1'b1;
         all_seen = 1;
         for (int k = 0; k < ND; k++) if (!m_seen[k]) all_seen = 0;
         if (all_seen != 0) m_pending = 1'b1;
      end
   endtask

   task automatic step(input logic [ND-1:0] a, input logic [7:0] c, input logic rst);
      anode = a; cathode = c; reset = rst;
      @(posedge clk);
      edge_no++;
      model_edge(rst, a, c);
      #1;
      if (valid === 1'b1) begin valid_seen++; last_valid_edge = edge_no; end
      check_value("valid", {31'd0, valid}, {31'd0, m_valid});
      check_value("digits", {16'd0, digits}, {16'd0, m_out_digits});
      check_value("dp", {28'd0, dp}, {28'd0, m_out_dp});
      check_value("frame_err", {31'd0, frame_err}, {31'd0, m_out_err});
   endtask

   task automatic dwell(input int k, input logic [7:0] c, input int n);
      logic [ND-1:0] a;
      a = ~(4'b0001 << k);
      repeat (n) step(a, c, 1'b0);
   endtask

   task automatic blank(input int n);
      repeat (n) step(4'b1111, 8'hFF, 1'b0);
   endtask

   int v0, e_start, sel, dw;
   logic [ND-1:0] ra;
   logic [7:0] rc;

   initial begin
      reset = 1'b1; anode = 4'b1111; cathode = 8'hFF;
      repeat (3) step(4'b1111, 8'hFF, 1'b1);
      check_value("rst_digits", {16'd0, digits}, 32'd0);
      check_value("rst_valid", {31'd0, valid}, 32'd0);
      v0 = valid_seen;
      blank(100);
      check_value("blank_no_valid", valid_seen - v0, 32'd0);

      // basic scan and publish latency
      v0 = valid_seen;
      dwell(0, 8'hC0, 8); dwell(1, 8'hF9, 8); dwell(2, 8'hA4, 8);
      e_start = edge_no + 1;
      dwell(3, 8'hB0, 8);
      blank(4);
      check_value("scan1_pulses", valid_seen - v0, 32'd1);
      check_value("scan1_latency", last_valid_edge, e_start + SC);
      check_value("scan1_digits", {16'd0, digits}, 32'h3210);
      check_value("scan1_dp", {28'd0, dp}, 32'h0);
      check_value("scan1_err", {31'd0, frame_err}, 32'd0);

      // unrecognised pattern plus decimal point
      v0 = valid_seen;
      dwell(0, 8'hC0, 8); dwell(1, 8'hFF, 8); dwell(2, 8'h12, 8); dwell(3, 8'hB0, 8);
      blank(4);
      check_value("scan2_pulses", valid_seen - v0, 32'd1);
      check_value("scan2_digits", {16'd0, digits}, 32'h35F0);
      check_value("scan2_dp", {28'd0, dp}, 32'h4);
      check_value("scan2_err", {31'd0, frame_err}, 32'd1);

      // short dwell rejected
      v0 = valid_seen;
      dwell(0, 8'hC0, 8); dwell(1, 8'hF9, 8); dwell(2, 8'hA4, 8); dwell(3, 8'hB0, 3);
      blank(10);
      check_value("short_no_valid", valid_seen - v0, 32'd0);
      dwell(3, 8'hB0, 8);
      blank(4);
      check_value("short_then_full", valid_seen - v0, 32'd1);

      // multiple-low select never captures
      v0 = valid_seen;
      dwell(0, 8'h99, 8); dwell(1, 8'h92, 8);
      repeat (20) step(4'b1100, 8'h80, 1'b0);
      dwell(2, 8'h82, 8);
      blank(6);
      check_value("multi_no_valid", valid_seen - v0, 32'd0);
      dwell(3, 8'hF8, 8);
      blank(4);
      check_value("multi_then_full", valid_seen - v0, 32'd1);
      check_value("multi_digits", {16'd0, digits}, 32'h7654);

      // reset mid-frame discards partial captures
      dwell(0, 8'h99, 8); dwell(1, 8'h92, 8); dwell(2, 8'h82, 8);
      repeat (2) step(4'b1111, 8'hFF, 1'b1);
      check_value("midrst_digits", {16'd0, digits}, 32'd0);
      v0 = valid_seen;
      dwell(3, 8'hC0, 8);
      blank(6);
      check_value("midrst_no_valid", valid_seen - v0, 32'd0);
      dwell(0, 8'hF8, 8); dwell(1, 8'h80, 8); dwell(2, 8'h90, 8); dwell(3, 8'hC0, 8);
      blank(4);
      check_value("midrst_pulses", valid_seen - v0, 32'd1);
      check_value("midrst_digits_new", {16'd0, digits}, 32'h0987);

      // random scans, dwells, ghosts and illegal selects
      for (int it = 0; it < 400; it++) begin
         sel = $urandom_range(0, 5);
         if (sel < 4) ra = ~(4'b0001 << sel);
         else if (sel == 4) ra = 4'b1111;
         else ra = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) begin
            rc = {1'($urandom_range(0, 1)), seg_tbl[$urandom_range(0, 9)]};
         end else begin
            rc = 8'($urandom_range(0, 255));
         end
         dw = $urandom_range(1, 9);
         repeat (dw) step(ra, rc, 1'b0);
      end
      blank(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
